// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - state, display and operation encodings for the calculator sequencer
package calc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE1  = 4'd0,
    ST_LOAD1  = 4'd1,
    ST_IDLE2  = 4'd2,
    ST_LOAD2  = 4'd3,
    ST_SELECT = 4'd4,
    ST_START  = 4'd5,
    ST_WAIT   = 4'd6,
    ST_DONE   = 4'd7,
    ST_ERROR  = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    LED_OPERANDS = 2'b00,
    LED_BUSY     = 2'b01,
    LED_RESULT   = 2'b10,
    LED_ERROR    = 2'b11
  } ledsel_t;

  localparam int TIMEOUT_CYC_DEFAULT = 255;
  localparam int CNT_W               = 10;
  localparam logic [2:0] MS_BAD_LO   = 3'd6;
  localparam logic [2:0] MS_BAD_HI   = 3'd7;

  // Opcodes the ALU cannot execute; these never launch it.
  function automatic logic ms_invalid(input logic [2:0] ms);
    return (ms == MS_BAD_LO) || (ms == MS_BAD_HI);
  endfunction

  function automatic ledsel_t led_for(input state_t s);
    case (s)
      ST_SELECT, ST_START, ST_WAIT: return LED_BUSY;
      ST_DONE:                      return LED_RESULT;
      ST_ERROR:                     return LED_ERROR;
      default:                      return LED_OPERANDS;
    endcase
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - active-low button synchronizer with one-shot press detection
module btn_sync_edge (
  input  logic CLK,
  input  logic clear,
  input  logic btn_n,
  output logic press
);

  logic sync1, sync2;
  logic live1, live2;
  logic high1, high2;

  // high1/high2 only count samples that really came from btn_n, so reset
  // values never arm a press when the button is already held at release.
  always_ff @(posedge CLK or negedge clear) begin
    if (!clear) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      live1 <= 1'b0;
      live2 <= 1'b0;
      high1 <= 1'b0;
      high2 <= 1'b0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      live1 <= 1'b1;
      live2 <= live1;
      high1 <= sync2 & live2;
      high2 <= high1;
    end
  end

  assign press = ~sync2 & high1 & high2;

endmodule

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - operand load / op select / ALU handshake sequencer
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic       CLK,
  input  logic       clear,
  input  logic       next,
  input  logic [2:0] MS,
  input  logic       alu_done,
  input  logic       alu_err,
  output logic       alu_start,
  output logic       WE,
  output logic       W1,
  output logic [3:0] MS_out,
  output logic [1:0] LEDsel,
  output logic       Done_out,
  output logic       err_out,
  output logic [3:0] cs_out
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state;
  logic [2:0]       ms_lat;
  logic [CNT_W-1:0] wait_cnt;
  logic             press;

  btn_sync_edge u_btn (
    .CLK   (CLK),
    .clear (clear),
    .btn_n (next),
    .press (press)
  );

  always_ff @(posedge CLK or negedge clear) begin
    if (!clear) begin
      state    <= ST_IDLE1;
      ms_lat   <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE1:  if (press) state <= ST_LOAD1;
        ST_LOAD1:  state <= ST_IDLE2;
        ST_IDLE2:  if (press) state <= ST_LOAD2;
        ST_LOAD2:  state <= ST_SELECT;
        ST_SELECT: if (press) begin
          state  <= ST_START;
          ms_lat <= MS;
        end
        ST_START: begin
          wait_cnt <= '0;
          state    <= ms_invalid(ms_lat) ? ST_ERROR : ST_WAIT;
        end
        // A completion in the last allowed cycle beats the timeout.
        ST_WAIT: begin
          if (alu_done)                     state <= alu_err ? ST_ERROR : ST_DONE;
          else if (wait_cnt == TIMEOUT_LAST) state <= ST_ERROR;
          else                              wait_cnt <= wait_cnt + CNT_W'(1);
        end
        ST_DONE, ST_ERROR: if (press) state <= ST_IDLE1;
        default: state <= ST_IDLE1;
      endcase
    end
  end

  always_comb begin
    alu_start = (state == ST_START) && !ms_invalid(ms_lat);
    WE        = (state == ST_LOAD1) || (state == ST_LOAD2);
    W1        = !((state == ST_IDLE1) || (state == ST_LOAD1));
    case (state)
      ST_SELECT:                  MS_out = {1'b0, MS};
      ST_START, ST_WAIT, ST_DONE: MS_out = {1'b0, ms_lat};
      default:                    MS_out = 4'd0;
    endcase
    LEDsel   = led_for(state);
    Done_out = (state == ST_DONE);
    err_out  = (state == ST_ERROR);
    cs_out   = state;
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb/tb_calc_sequencer.sv - table, directed and randomized checks of calc_sequencer
`timescale 1ns/1ps
module tb_calc_sequencer;

  logic       CLK = 1'b0, clear = 1'b1, next = 1'b1, alu_done = 1'b0, alu_err = 1'b0;
  logic [2:0] MS = 3'd0;
  logic       a_start, a_we, a_w1, a_done, a_err, b_start, b_we, b_w1, b_done, b_err;
  logic [3:0] a_ms, a_cs, b_ms, b_cs;
  logic [1:0] a_led, b_led;
  logic [14:0] a_vec, b_vec;

  calc_sequencer dut_a (
    .CLK(CLK), .clear(clear), .next(next), .MS(MS), .alu_done(alu_done), .alu_err(alu_err),
    .alu_start(a_start), .WE(a_we), .W1(a_w1), .MS_out(a_ms), .LEDsel(a_led),
    .Done_out(a_done), .err_out(a_err), .cs_out(a_cs));

  calc_sequencer #(.TIMEOUT_CYC(8)) dut_b (
    .CLK(CLK), .clear(clear), .next(next), .MS(MS), .alu_done(alu_done), .alu_err(alu_err),
    .alu_start(b_start), .WE(b_we), .W1(b_w1), .MS_out(b_ms), .LEDsel(b_led),
    .Done_out(b_done), .err_out(b_err), .cs_out(b_cs));

  assign a_vec = {a_start, a_we, a_w1, a_ms, a_led, a_done, a_err, a_cs};
  assign b_vec = {b_start, b_we, b_w1, b_ms, b_led, b_done, b_err, b_cs};

  always #5 CLK = ~CLK;

  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  localparam int S_IDLE1 = 0, S_LOAD1 = 1, S_IDLE2 = 2, S_LOAD2 = 3, S_SELECT = 4;
  localparam int S_START = 5, S_WAIT = 6, S_DONE = 7, S_ERROR = 8;

  typedef struct { int st; int lat; int waited; } model_t;
  model_t ma, mb;
  bit     smp[$];

  function automatic model_t step(model_t m, bit p, logic [2:0] ms, bit dn, bit er, int to);
    model_t r = m;
    case (m.st)
      S_IDLE1:  if (p) r.st = S_LOAD1;
      S_LOAD1:  r.st = S_IDLE2;
      S_IDLE2:  if (p) r.st = S_LOAD2;
      S_LOAD2:  r.st = S_SELECT;
      S_SELECT: if (p) begin r.st = S_START; r.lat = int'(ms); end
      S_START:  begin r.st = (m.lat >= 6) ? S_ERROR : S_WAIT; r.waited = 0; end
      S_WAIT:   if (dn) r.st = er ? S_ERROR : S_DONE;
                else begin r.waited = m.waited + 1; if (r.waited >= to) r.st = S_ERROR; end
      default:  if (p) r.st = S_IDLE1;
    endcase
    return r;
  endfunction

  function automatic logic [14:0] expect_out(model_t m, logic [2:0] ms_live);
    logic [3:0] mso;
    logic [1:0] led;
    if (m.st == S_SELECT) mso = {1'b0, ms_live};
    else if (m.st inside {S_START, S_WAIT, S_DONE}) mso = {1'b0, 3'(m.lat)};
    else mso = 4'd0;
    led = (m.st <= S_LOAD2) ? 2'd0 : (m.st <= S_WAIT) ? 2'd1 : (m.st == S_DONE) ? 2'd2 : 2'd3;
    return {(m.st == S_START) && (m.lat < 6), (m.st == S_LOAD1) || (m.st == S_LOAD2),
            !((m.st == S_IDLE1) || (m.st == S_LOAD1)), mso, led,
            m.st == S_DONE, m.st == S_ERROR, 4'(m.st)};
  endfunction

  // Press = a sample seen low that was preceded by two real high samples,
  // acted upon two edges after the low sample.
  always @(posedge CLK or negedge clear) begin
    if (!clear) begin
      ma = '{S_IDLE1, 0, 0};
      mb = '{S_IDLE1, 0, 0};
      smp.delete();
    end else begin
      bit p;
      p = (smp.size() >= 4) && !smp[$-1] && smp[$-2] && smp[$-3];
      ma = step(ma, p, MS, alu_done, alu_err, 255);
      mb = step(mb, p, MS, alu_done, alu_err, 8);
      smp.push_back(next);
      if (smp.size() > 8) void'(smp.pop_front());
    end
  end

  bit chk_en = 0;
  int n_load1 = 0, n_load2 = 0, n_start = 0;

  always @(negedge CLK) begin
    if (chk_en) begin
      check("model_a", a_vec, expect_out(ma, MS));
      check("model_b", b_vec, expect_out(mb, MS));
      if (a_we && !a_w1) n_load1++;
      if (a_we && a_w1)  n_load2++;
      if (a_start)       n_start++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(negedge CLK); #1; end
  endtask

  task automatic press();
    next = 1'b0; tick(4); next = 1'b1; tick(3);
  endtask

  task automatic to_start(input logic [2:0] ms);
    press(); press();
    MS = ms; next = 1'b0; tick(3); next = 1'b1;
  endtask

  typedef struct { bit nx; logic [2:0] ms; bit dn; int hold; int cs_a; } vec_t;
  vec_t tbl[$];

  task automatic add(input bit nx, input int ms, input bit dn, input int hold, input int cs);
    vec_t v;
    v.nx = nx; v.ms = 3'(ms); v.dn = dn; v.hold = hold; v.cs_a = cs;
    tbl.push_back(v);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    add(1,0,0, 5,0); add(0,0,0, 4,2); add(1,0,0, 3,2); add(0,0,0, 4,4); add(1,0,0, 3,4);
    add(0,3,0, 3,5); add(1,3,0, 1,6); add(1,5,0, 9,6); add(1,5,1, 1,7); add(1,5,0, 2,7);
    add(0,5,0, 4,0); add(1,5,0, 3,0);
    add(0,0,0,50,2); add(1,0,0, 3,2); add(1,0,1, 1,2); add(1,0,0, 2,2);
    add(0,0,0, 4,4); add(1,0,0, 3,4); add(0,7,0, 3,5); add(1,7,0, 1,8); add(1,7,0, 3,8);
    add(0,7,0, 4,0); add(1,7,0, 3,0);

    #2 clear = 1'b0;
    tick(2);
    check("reset_a", a_vec, 15'd0);
    check("reset_b", b_vec, 15'd0);
    clear = 1'b1;
    chk_en = 1;

    foreach (tbl[i]) begin
      next = tbl[i].nx; MS = tbl[i].ms; alu_done = tbl[i].dn; alu_err = 1'b0;
      tick(tbl[i].hold);
      check($sformatf("tbl%0d_cs", i), {11'd0, a_cs}, {11'd0, 4'(tbl[i].cs_a)});
      if (i == 9)  check("pass_done_vec", a_vec, {3'b001, 4'd3, 2'b10, 2'b10, 4'd7});
      if (i == 20) check("ms7_err_vec", a_vec, {3'b001, 4'd0, 2'b11, 2'b01, 4'd8});
    end
    check("load1_pulses", 15'(n_load1), 15'd2);
    check("load2_pulses", 15'(n_load2), 15'd2);
    check("start_pulses", 15'(n_start), 15'd1);

    to_start(3'd2);
    check("b_start", {11'd0, b_cs}, 15'd5);
    tick(1); tick(7);
    check("b_wait_c8", {11'd0, b_cs}, 15'd6);
    tick(1);
    check("b_timeout", {11'd0, b_cs}, 15'd8);
    check("a_still_wait", {11'd0, a_cs}, 15'd6);
    alu_done = 1'b1; tick(1); alu_done = 1'b0;
    check("a_done", {11'd0, a_cs}, 15'd7);
    press();
    to_start(3'd2);
    tick(1); tick(7);
    alu_done = 1'b1; tick(1); alu_done = 1'b0;
    check("b_done_on_last", {11'd0, b_cs}, 15'd7);
    press();

    to_start(3'd4);
    tick(2);
    alu_done = 1'b1; alu_err = 1'b1; tick(1); alu_done = 1'b0; alu_err = 1'b0;
    check("alu_err_a", {11'd0, a_cs}, 15'd8);
    check("alu_err_b", {11'd0, b_cs}, 15'd8);
    press();

    to_start(3'd1);
    tick(3);
    #2 clear = 1'b0;
    #1 check("clear_async_a", a_vec, 15'd0);
    check("clear_async_b", b_vec, 15'd0);
    tick(2);
    clear = 1'b1; alu_done = 1'b1; tick(1); alu_done = 1'b0; tick(2);
    check("late_done_ignored", a_vec, 15'd0);

    next = 1'b0; tick(1);
    clear = 1'b0; tick(2); clear = 1'b1; tick(10);
    check("held_at_release", {11'd0, a_cs}, 15'd0);
    next = 1'b1; tick(4);
    press();
    check("press_after_release", {11'd0, a_cs}, 15'd2);

    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(0, 5) == 0) next = ~next;
      MS = 3'($urandom);
      alu_done = ($urandom_range(0, 11) == 0);
      alu_err  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 400) == 0) begin clear = 1'b0; tick(1); clear = 1'b1; end
      tick(1);
    end
    alu_done = 1'b0;
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
